imem_fetch_ctrl: RTL and testbench

IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

---
 rtl/mips_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 64 ++++++
 rtl/imem_fetch_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the instruction-fetch front end:
//                fetch FSM state encoding, default reset PC and NOP word.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  // First fetch address after reset (MIPS user text segment base)
  localparam logic [31:0] C_RESET_PC = 32'h0040_0000;

  // Instruction value presented while no live instruction is held
  localparam logic [31:0] C_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // leaving reset, no request yet
    ST_REQ  = 2'd1,  // request presented, waiting for grant
    ST_WAIT = 2'd2,  // request granted, waiting for read data
    ST_FULL = 2'd3   // output and skid both occupied, fetch paused
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_skid_buf
//  Description : Single-entry holding register for one fetched instruction
//                and its PC+4, used when a response lands while the decode
//                stage is stalled and the output slot is still occupied.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                load            - capture instr_in / pc_plus_4_in
//                clear           - drop the held entry (wins over load)
//                instr_in, pc_plus_4_in - entry to capture
//                valid, instr, pc_plus_4 - held entry
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buf
  import mips_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            clear,
  input  logic [31:0]     instr_in,
  input  logic [PC_W-1:0] pc_plus_4_in,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [PC_W-1:0] pc_plus_4
);

  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc_plus_4_q, pc_plus_4_d;

  always_comb begin
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_plus_4_d = pc_plus_4_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d     = 1'b1;
      instr_d     = instr_in;
      pc_plus_4_d = pc_plus_4_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      instr_q     <= C_NOP;
      pc_plus_4_q <= '0;
    end else begin
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_plus_4_q <= pc_plus_4_d;
    end
  end

  assign valid     = valid_q;
  assign instr     = instr_q;
  assign pc_plus_4 = pc_plus_4_q;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_fetch_ctrl
//  Description : Instruction-fetch controller. Issues one instruction-memory
//                read at a time, presents the returned word with its PC+4 to
//                the decode register, buffers one extra word while decode is
//                stalled, and handles jr/jump/branch redirects by discarding
//                any in-flight response.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                stall_f               - decode not accepting, hold output
//                branch/jump/jump_reg  - redirects (+ *_addr targets)
//                imem_req/imem_addr    - read request and word address
//                imem_gnt              - request accepted this cycle
//                imem_rvalid/imem_rdata- read response
//                valid_f/instr_f/pc_plus_4_f - fetch output to decode
//                perf_fetched/perf_killed    - performance counters
//  Config      : IMEM_FETCH_PERF_EN - when defined, perf_* are saturating
//                counters; otherwise they are tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
  import mips_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(C_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_f,
  input  logic            branch,
  input  logic [PC_W-1:0] branch_addr,
  input  logic            jump,
  input  logic [PC_W-1:0] jump_addr,
  input  logic            jump_reg,
  input  logic [PC_W-1:0] jump_reg_addr,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            valid_f,
  output logic [31:0]     instr_f,
  output logic [PC_W-1:0] pc_plus_4_f,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_killed
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_req_q, pc_req_d;
  logic            kill_q, kill_d;
  logic            valid_f_q, valid_f_d;
  logic [31:0]     instr_f_q, instr_f_d;
  logic [PC_W-1:0] pc_plus_4_f_q, pc_plus_4_f_d;

  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            skid_load, skid_clear, skid_valid;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc_plus_4;
  logic            fetched_inc, killed_inc;

  // jr has highest priority, then j/jal, then branch; target is word-aligned
  always_comb begin
    redirect = jump_reg | jump | branch;
    if (jump_reg)  redirect_pc = jump_reg_addr;
    else if (jump) redirect_pc = jump_addr;
    else           redirect_pc = branch_addr;
    redirect_pc[1:0] = 2'b00;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pc_req_d      = pc_req_q;
    kill_d        = kill_q;
    valid_f_d     = valid_f_q;
    instr_f_d     = instr_f_q;
    pc_plus_4_f_d = pc_plus_4_f_q;
    skid_load     = 1'b0;
    skid_clear    = 1'b0;
    fetched_inc   = 1'b0;
    killed_inc    = 1'b0;

    // Output is consumed whenever decode is not stalled
    if (valid_f_q && !stall_f) valid_f_d = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_gnt) begin
          pc_req_d = pc_q;
          pc_d     = pc_q + PC_W'(4);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d     = 1'b0;
            killed_inc = 1'b1;
            state_d    = ST_REQ;
          end else if (!valid_f_q || !stall_f) begin
            valid_f_d     = 1'b1;
            instr_f_d     = imem_rdata;
            pc_plus_4_f_d = pc_req_q + PC_W'(4);
            fetched_inc   = 1'b1;
            state_d       = ST_REQ;
          end else begin
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end
        end
      end
      ST_FULL: begin
        if (!stall_f && skid_valid) begin
          valid_f_d     = 1'b1;
          instr_f_d     = skid_instr;
          pc_plus_4_f_d = skid_pc_plus_4;
          skid_clear    = 1'b1;
          fetched_inc   = 1'b1;
          state_d       = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A redirect flushes everything regardless of stall_f. A request that
    // is granted in the redirect cycle, or one already in flight, still owes
    // a response: mark it killed and wait for it before requesting again.
    if (redirect) begin
      pc_d        = redirect_pc;
      valid_f_d   = 1'b0;
      skid_load   = 1'b0;
      skid_clear  = 1'b1;
      fetched_inc = 1'b0;
      case (state_q)
        ST_REQ: begin
          kill_d  = imem_gnt;
          state_d = imem_gnt ? ST_WAIT : ST_REQ;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            kill_d     = 1'b0;
            killed_inc = 1'b1;
            state_d    = ST_REQ;
          end else begin
            kill_d  = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      pc_req_q      <= RESET_PC;
      kill_q        <= 1'b0;
      valid_f_q     <= 1'b0;
      instr_f_q     <= C_NOP;
      pc_plus_4_f_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pc_req_q      <= pc_req_d;
      kill_q        <= kill_d;
      valid_f_q     <= valid_f_d;
      instr_f_q     <= instr_f_d;
      pc_plus_4_f_q <= pc_plus_4_f_d;
    end
  end

  fetch_skid_buf #(
    .PC_W (PC_W)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (skid_load),
    .clear        (skid_clear),
    .instr_in     (imem_rdata),
    .pc_plus_4_in (pc_req_q + PC_W'(4)),
    .valid        (skid_valid),
    .instr        (skid_instr),
    .pc_plus_4    (skid_pc_plus_4)
  );

  assign imem_req    = (state_q == ST_REQ);
  assign imem_addr   = pc_q;
  assign valid_f     = valid_f_q;
  assign instr_f     = instr_f_q;
  assign pc_plus_4_f = pc_plus_4_f_q;

`ifdef IMEM_FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_killed_q, perf_killed_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_killed_d  = perf_killed_q;
    if (fetched_inc && (perf_fetched_q != 32'hFFFF_FFFF))
      perf_fetched_d = perf_fetched_q + 32'd1;
    if (killed_inc && (perf_killed_q != 32'hFFFF_FFFF))
      perf_killed_d = perf_killed_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_killed_q  <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_killed_q  <= perf_killed_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_killed  = perf_killed_q;
`else
  logic unused_perf_inc;
  assign unused_perf_inc = fetched_inc | killed_inc;
  assign perf_fetched    = '0;
  assign perf_killed     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_imem_fetch_ctrl
//  Description : Self-checking bench for imem_fetch_ctrl. A memory model
//                answers granted requests after a programmable delay; a
//                scoreboard queues the expected instruction/PC+4 for each
//                accepted grant and compares when decode consumes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_f = 1'b0;
  logic        branch = 1'b0, jump = 1'b0, jump_reg = 1'b0;
  logic [31:0] branch_addr = '0, jump_addr = '0, jump_reg_addr = '0;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req, valid_f;
  logic [31:0] imem_addr, instr_f, pc_plus_4_f, perf_fetched, perf_killed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] grant_log[$];
  int          wait_cnt = 0;
  int          rsp_delay = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_i, hold_p;

  imem_fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_f       (stall_f),
    .branch        (branch),
    .branch_addr   (branch_addr),
    .jump          (jump),
    .jump_addr     (jump_addr),
    .jump_reg      (jump_reg),
    .jump_reg_addr (jump_reg_addr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .valid_f       (valid_f),
    .instr_f       (instr_f),
    .pc_plus_4_f   (pc_plus_4_f),
    .perf_fetched  (perf_fetched),
    .perf_killed   (perf_killed)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0x0040_0000 holds 0x2002_0005
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h2042_0005;
  endfunction

  // Memory responder (negedge+1) and scoreboard monitor (1 ns before posedge)
  always begin : mon
    exp_t        e;
    logic        redir;
    @(negedge clk);
    #1;
    imem_rvalid = 1'b0;
    if (pend_q.size() > 0) begin
      if (wait_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(pend_q.pop_front());
        wait_cnt    = rsp_delay;
      end else begin
        wait_cnt--;
      end
    end
    #3;
    if (!rst_n) begin
      exp_q.delete();
      hold_v = 1'b0;
    end else begin
      redir = jump_reg | jump | branch;
      if (hold_v) begin
        checks++;
        if ({valid_f, instr_f, pc_plus_4_f} !== {1'b1, hold_i, hold_p}) begin
          errors++;
          $display("FAIL stall_hold: got v=%b i=%h p=%h want v=1 i=%h p=%h",
                   valid_f, instr_f, pc_plus_4_f, hold_i, hold_p);
        end
      end
      hold_v = valid_f && stall_f && !redir;
      hold_i = instr_f;
      hold_p = pc_plus_4_f;
      if (redir) begin
        exp_q.delete();
      end else begin
        if (valid_f && !stall_f) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got i=%h p=%h want nothing", instr_f, pc_plus_4_f);
          end else begin
            e = exp_q.pop_front();
            if (instr_f !== e.instr || pc_plus_4_f !== e.pc4) begin
              errors++;
              $display("FAIL sb_data: got i=%h p=%h want i=%h p=%h",
                       instr_f, pc_plus_4_f, e.instr, e.pc4);
            end
          end
        end
        if (imem_req && imem_gnt) begin
          exp_q.push_back('{instr: memf(imem_addr), pc4: imem_addr + 32'd4});
          grant_log.push_back(imem_addr);
        end
      end
      if (imem_req && imem_gnt) begin
        if (pend_q.size() == 0) wait_cnt = rsp_delay;
        pend_q.push_back(imem_addr);
      end
    end
  end

  // Wait helpers: test now (at negedge+3), else advance one cycle at a time
  task automatic wait_grant(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (imem_req && imem_gnt) begin ok = 1'b1; break; end
      @(negedge clk); #3;
    end
  endtask

  task automatic wait_valid(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (valid_f) begin ok = 1'b1; break; end
      @(negedge clk); #3;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checks++;
    if (imem_req !== 1'b0 || valid_f !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got req=%b v=%b want 0 0", imem_req, valid_f);
    end
    checks++;
    if (instr_f !== 32'h0 || pc_plus_4_f !== 32'h0) begin
      errors++; $display("FAIL reset_out: got i=%h p=%h want 0 0", instr_f, pc_plus_4_f);
    end
    checks++;
    if (imem_addr !== RST_PC) begin
      errors++; $display("FAIL reset_addr: got %h want %h", imem_addr, RST_PC);
    end
    checks++;
    if (perf_fetched !== 32'h0 || perf_killed !== 32'h0) begin
      errors++; $display("FAIL reset_perf: got %h %h want 0 0", perf_fetched, perf_killed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_gnt = 1'b1;
    #3;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_req: got %b want 0", imem_req);
    end
  endtask

  task automatic test_basic();
    logic ok;
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== RST_PC) begin
      errors++; $display("FAIL first_addr: got ok=%b addr=%h want %h", ok, imem_addr, RST_PC);
    end
    @(negedge clk); #3;
    wait_valid(ok);
    checks++;
    if (!ok || instr_f !== 32'h2002_0005 || pc_plus_4_f !== 32'h0040_0004) begin
      errors++; $display("FAIL first_data: got ok=%b i=%h p=%h want i=20020005 p=00400004",
                         ok, instr_f, pc_plus_4_f);
    end
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== 32'h0040_0004) begin
      errors++; $display("FAIL second_addr: got ok=%b addr=%h want 00400004", ok, imem_addr);
    end
  endtask

  task automatic test_stall();
    logic [31:0] si, sp;
    @(negedge clk);
    stall_f = 1'b1;
    repeat (6) @(negedge clk);
    #3;
    checks++;
    if (imem_req !== 1'b0 || valid_f !== 1'b1 || instr_f !== memf(32'h0040_0004)) begin
      errors++; $display("FAIL stall_full: got req=%b v=%b i=%h want req=0 v=1 i=%h",
                         imem_req, valid_f, instr_f, memf(32'h0040_0004));
    end
    si = instr_f;
    sp = pc_plus_4_f;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #3;
      checks++;
      if (imem_req !== 1'b0 || instr_f !== si || pc_plus_4_f !== sp) begin
        errors++; $display("FAIL stall_stable: got req=%b i=%h p=%h want req=0 i=%h p=%h",
                           imem_req, instr_f, pc_plus_4_f, si, sp);
      end
    end
    @(negedge clk);
    stall_f = 1'b0;
    @(negedge clk); #3;
    checks++;
    if (valid_f !== 1'b1 || instr_f !== memf(32'h0040_0008) ||
        pc_plus_4_f !== 32'h0040_000C || imem_req !== 1'b1) begin
      errors++; $display("FAIL skid_out: got v=%b i=%h p=%h req=%b want v=1 i=%h p=0040000c req=1",
                         valid_f, instr_f, pc_plus_4_f, imem_req, memf(32'h0040_0008));
    end
  endtask

  task automatic test_redirect_wait();
    logic ok;
    @(negedge clk);
    rsp_delay = 3;
    #3;
    wait_grant(ok);
    @(negedge clk);
    jump = 1'b1; jump_addr = 32'h0040_0100;
    branch = 1'b1; branch_addr = 32'h0040_0500;
    rsp_delay = 0;
    @(negedge clk);
    jump = 1'b0; branch = 1'b0;
    #3;
    checks++;
    if (!ok || valid_f !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL kill_wait: got ok=%b v=%b req=%b want ok=1 v=0 req=0", ok, valid_f, imem_req);
    end
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== 32'h0040_0100 || valid_f !== 1'b0) begin
      errors++; $display("FAIL jump_addr: got ok=%b addr=%h v=%b want 00400100 v=0", ok, imem_addr, valid_f);
    end
  endtask

  task automatic test_jump_reg();
    logic ok;
    @(negedge clk);
    jump_reg = 1'b1; jump_reg_addr = 32'h0040_0203;
    jump = 1'b1; jump_addr = 32'h0040_0700;
    @(negedge clk);
    jump_reg = 1'b0; jump = 1'b0;
    #3;
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== 32'h0040_0200) begin
      errors++; $display("FAIL jr_addr: got ok=%b addr=%h want 00400200", ok, imem_addr);
    end
  endtask

  task automatic test_wrap();
    logic ok;
    @(negedge clk);
    jump = 1'b1; jump_addr = 32'hFFFF_FFFC;
    @(negedge clk);
    jump = 1'b0;
    #3;
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_addr: got ok=%b addr=%h want fffffffc", ok, imem_addr);
    end
    @(negedge clk); #3;
    wait_valid(ok);
    checks++;
    if (!ok || pc_plus_4_f !== 32'h0 || instr_f !== memf(32'hFFFF_FFFC)) begin
      errors++; $display("FAIL wrap_data: got ok=%b i=%h p=%h want i=%h p=00000000",
                         ok, instr_f, pc_plus_4_f, memf(32'hFFFF_FFFC));
    end
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_next: got ok=%b addr=%h want 00000000", ok, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    @(negedge clk);
    rsp_delay = 3;
    #3;
    wait_grant(ok);
    @(negedge clk);
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    #3;
    checks++;
    if (!ok || perf_fetched !== 32'h0 || perf_killed !== 32'h0 || valid_f !== 1'b0 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL mid_reset: got ok=%b pf=%h pk=%h v=%b addr=%h want ok=1 0 0 0 %h",
                         ok, perf_fetched, perf_killed, valid_f, imem_addr, RST_PC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rsp_delay = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #3;
      checks++;
      if (valid_f !== 1'b0) begin
        errors++; $display("FAIL late_rvalid: got v=%b want 0", valid_f);
      end
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
      errors++; $display("FAIL restart_req: got req=%b addr=%h want 1 %h", imem_req, imem_addr, RST_PC);
    end
    @(negedge clk);
    imem_gnt = 1'b1;
    #3;
    wait_grant(ok);
    checks++;
    if (!ok || imem_addr !== RST_PC) begin
      errors++; $display("FAIL restart_addr: got ok=%b addr=%h want %h", ok, imem_addr, RST_PC);
    end
    @(negedge clk); #3;
    wait_valid(ok);
    checks++;
    if (!ok || instr_f !== 32'h2002_0005 || pc_plus_4_f !== 32'h0040_0004) begin
      errors++; $display("FAIL restart_data: got ok=%b i=%h p=%h want 20020005 00400004",
                         ok, instr_f, pc_plus_4_f);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_jump_reg();
    test_wrap();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
